irb_port_arbiter: RTL and testbench
===================================

Name: irb_port_arbiter

Overview:
- Shares the single-port 64x8 IRB image buffer between two masters.
- Master 0 is the LCD controller write-back stream; master 1 is the display refresh reader.
- Round-robin ownership with burst lock and forced handoff after MAX_BURST beats.
- Drives the IRB SRAM pins directly and routes 1-cycle-latency read data back to the issuing master.

Parameters:
AW, 6, IRB address width (64 words)
DW, 8, IRB data width
MAX_BURST, 8, max consecutive beats an owner keeps the port while the other master is requesting (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
m0_req  input  1  master 0 beat request
m0_rw  input  1  master 0 direction: 1 = read, 0 = write
m0_addr  input  AW  master 0 word address
m0_wdata  input  DW  master 0 write data
m0_last  input  1  master 0 final beat of burst
m0_gnt  output  1  master 0 beat accepted this cycle
m0_rvalid  output  1  master 0 read data valid
m0_rdata  output  DW  master 0 read data
m1_req, m1_rw, m1_addr, m1_wdata, m1_last, m1_gnt, m1_rvalid, m1_rdata  same as m0_* for master 1
IRB_CEN  output  1  SRAM chip enable, active-low
IRB_WEN  output  1  SRAM write enable, active-low (1 = read)
IRB_A  output  AW  SRAM address
IRB_D  output  DW  SRAM write data
IRB_Q  input  DW  SRAM read data, valid one cycle after a read beat

Behaviour:
- State register `owner`: IDLE, OWN0, OWN1. Priority pointer `ptr` names the master that wins a tie from IDLE.
- Reset (async, reset=0) clears state, any cycle including mid-burst:
  - owner=IDLE, ptr=0, burst count=0, pending read tag cleared.
  - Outputs: m*_gnt=0, m*_rvalid=0, IRB_CEN=1, IRB_WEN=1, IRB_A=0, IRB_D=0.
- m{i}_gnt is combinational: m{i}_gnt = (owner==OWN{i}) & m{i}_req. A beat completes on a clock edge with req&gnt.
- SRAM pins are combinational from the owner's signals during a beat:
  - IRB_CEN=0, IRB_WEN=m_rw, IRB_A=m_addr, IRB_D=m_wdata.
  - When there is no beat, IRB_CEN=1, IRB_WEN=1, IRB_A=0, IRB_D=0.
- Read return:
  - A read beat on edge N sets a registered rvalid for that master in cycle N+1.
  - m{i}_rdata=IRB_Q when m{i}_rvalid is high, else 0. The non-issuing master never sees rvalid.
- IDLE:
  - One req -> that master's OWN state next cycle.
  - Both req -> OWN{ptr}.
  - None -> stay IDLE.
  - Request-to-first-grant latency is 1 cycle.
- OWN{i}: ownership ends at the edge where any of these holds:
  - (a) a beat with m{i}_last=1 completes;
  - (b) m{i}_req=0;
  - (c) burst count reaches MAX_BURST and the other master is requesting.
- On ownership end:
  - ptr=other master.
  - If the other master is requesting, go directly to OWN{other} with no bubble; else go to IDLE.
- Burst count:
  - Cleared on entering any OWN state; +1 per completed beat.
  - Saturates at MAX_BURST when the other master is idle, and ownership then continues uninterrupted.
- A forced handoff (c) ignores m_last. The preempted master keeps req high and resumes when granted again; its address sequencing is its own responsibility.
- rw, addr and wdata changes while req=1 and gnt=0 are legal; only the values at the accepting edge matter.
- Write then read of the same address on consecutive beats returns the new data. The SRAM handles this; the arbiter adds no forwarding.

Optional Feature:
- Macro ARB_STAT_EN.
- When defined:
  - Adds output ports stat0_beats and stat1_beats, 16 bits each.
  - Each counts completed beats of its master, saturates at 16'hFFFF, and resets to 0.
  - Adds output stat_handoffs, 8 bits, saturating count of forced handoffs (rule c).
- When undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset release, only m0 writes 8 beats (addr 0..7, data 8'h10..8'h17, last on beat 8) -> gnt from cycle 2; IRB_CEN=0/IRB_WEN=0 for 8 cycles; IRB mem[0..7]=10..17; then IDLE with IRB_CEN=1.
- Both masters request simultaneously out of reset -> m0 granted first (ptr=0). After m0's last beat, m1 is granted the very next cycle with no bubble; ptr then favours m0.
- m1 issues 3 reads of addr 5 while mem[5]=8'hA5 -> m1_rvalid high the cycle after each accepted beat with m1_rdata=8'hA5; m0_rvalid stays 0.
- MAX_BURST=8: m0 streams 20 beats without last while m1 requests -> m0 gets exactly 8 beats, m1 then owns; with m1 idle, m0 gets all 20 consecutively.
- Drop reset to 0 mid-burst at beat 4 -> all gnt/rvalid=0 and IRB_CEN=1 immediately (asynchronously). After release, both requesting -> m0 granted first.
- ARB_STAT_EN build, scenario 4 -> stat0_beats=20, stat1_beats=m1 beat count, stat_handoffs=2.

Source files
------------

// File: rtl/irb_port_arbiter.sv
// Two-master round-robin arbiter for the single-port IRB SRAM; optional ARB_STAT_EN adds beat/handoff counters.
// Latency: first grant 1 cycle after request from IDLE; read data returns 1 cycle after the read beat.
// Backpressure: m*_gnt is combinational; the owner keeps the port until last, req drop, or MAX_BURST with contention.
module irb_port_arbiter #(
    parameter int AW        = 6,
    parameter int DW        = 8,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_rw,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_last,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_rw,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_last,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
`ifdef ARB_STAT_EN
    output logic [15:0]   stat0_beats,
    output logic [15:0]   stat1_beats,
    output logic [7:0]    stat_handoffs,
`endif
    output logic          IRB_CEN,
    output logic          IRB_WEN,
    output logic [AW-1:0] IRB_A,
    output logic [DW-1:0] IRB_D,
    input  logic [DW-1:0] IRB_Q
);

    localparam int            CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} owner_t;

    owner_t        r_owner, w_owner_nxt;
    logic          r_ptr, w_ptr_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic          r_rv0, r_rv1;
    logic          w_beat0, w_beat1, w_beat;
    logic          w_cur_req, w_cur_last, w_oth_req;
    logic          w_end_a, w_end_b, w_end_c, w_end;

    assign w_beat0 = (r_owner == OWN0) & m0_req;
    assign w_beat1 = (r_owner == OWN1) & m1_req;
    assign w_beat  = w_beat0 | w_beat1;

    always_comb begin
        w_cur_req  = 1'b0;
        w_cur_last = 1'b0;
        w_oth_req  = 1'b0;
        case (r_owner)
            OWN0: begin
                w_cur_req  = m0_req;
                w_cur_last = m0_last;
                w_oth_req  = m1_req;
            end
            OWN1: begin
                w_cur_req  = m1_req;
                w_cur_last = m1_last;
                w_oth_req  = m0_req;
            end
            default: ;
        endcase
    end

    // Count saturates at MAX_BURST so an uncontended owner streams on indefinitely.
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + {{(CW-1){1'b0}}, w_beat};
    assign w_end_a   = w_beat & w_cur_last;
    assign w_end_b   = ~w_cur_req;
    assign w_end_c   = (w_cnt_inc == CNT_MAX) & w_oth_req;
    assign w_end     = w_end_a | w_end_b | w_end_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner <= IDLE;
            r_ptr   <= 1'b0;
            r_cnt   <= '0;
            r_rv0   <= 1'b0;
            r_rv1   <= 1'b0;
        end else begin
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rv0   <= w_beat0 & m0_rw;
            r_rv1   <= w_beat1 & m1_rw;
        end
    end

    always_comb begin
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = w_cnt_inc;
        case (r_owner)
            IDLE: begin
                w_cnt_nxt = '0;
                if (m0_req & m1_req) w_owner_nxt = r_ptr ? OWN1 : OWN0;
                else if (m0_req)     w_owner_nxt = OWN0;
                else if (m1_req)     w_owner_nxt = OWN1;
            end
            OWN0: if (w_end) begin
                w_ptr_nxt   = 1'b1;
                w_owner_nxt = m1_req ? OWN1 : IDLE;
                w_cnt_nxt   = '0;
            end
            OWN1: if (w_end) begin
                w_ptr_nxt   = 1'b0;
                w_owner_nxt = m0_req ? OWN0 : IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_owner_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        m0_gnt    = w_beat0;
        m1_gnt    = w_beat1;
        IRB_CEN   = 1'b1;
        IRB_WEN   = 1'b1;
        IRB_A     = '0;
        IRB_D     = '0;
        if (w_beat0) begin
            IRB_CEN = 1'b0;
            IRB_WEN = m0_rw;
            IRB_A   = m0_addr;
            IRB_D   = m0_wdata;
        end else if (w_beat1) begin
            IRB_CEN = 1'b0;
            IRB_WEN = m1_rw;
            IRB_A   = m1_addr;
            IRB_D   = m1_wdata;
        end
        m0_rvalid = r_rv0;
        m1_rvalid = r_rv1;
        m0_rdata  = r_rv0 ? IRB_Q : '0;
        m1_rdata  = r_rv1 ? IRB_Q : '0;
    end

`ifdef ARB_STAT_EN
    logic [15:0] r_stat0, r_stat1;
    logic [7:0]  r_handoffs;
    logic        w_force;

    // Only a pure MAX_BURST preemption counts; a coinciding last or req drop is a normal end.
    assign w_force = (r_owner != IDLE) & w_end_c & ~w_end_a & ~w_end_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat0    <= '0;
            r_stat1    <= '0;
            r_handoffs <= '0;
        end else begin
            if (w_beat0 && r_stat0 != 16'hFFFF) r_stat0 <= r_stat0 + 16'd1;
            if (w_beat1 && r_stat1 != 16'hFFFF) r_stat1 <= r_stat1 + 16'd1;
            if (w_force && r_handoffs != 8'hFF) r_handoffs <= r_handoffs + 8'd1;
        end
    end

    assign stat0_beats   = r_stat0;
    assign stat1_beats   = r_stat1;
    assign stat_handoffs = r_handoffs;
`endif

endmodule

// File: tb/tb_irb_port_arbiter.sv
// Self-checking bench for irb_port_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_irb_port_arbiter;
    localparam int MB = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       m0_req, m0_rw, m0_last, m0_gnt, m0_rvalid;
    logic [5:0] m0_addr;
    logic [7:0] m0_wdata, m0_rdata;
    logic       m1_req, m1_rw, m1_last, m1_gnt, m1_rvalid;
    logic [5:0] m1_addr;
    logic [7:0] m1_wdata, m1_rdata;
    logic       IRB_CEN, IRB_WEN;
    logic [5:0] IRB_A;
    logic [7:0] IRB_D, IRB_Q;
`ifdef ARB_STAT_EN
    logic [15:0] stat0_beats, stat1_beats;
    logic [7:0]  stat_handoffs;
`endif

    always #5 clk = ~clk;

    irb_port_arbiter #(.AW(6), .DW(8), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_last(m0_last),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_last(m1_last),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
`ifdef ARB_STAT_EN
        .stat0_beats(stat0_beats), .stat1_beats(stat1_beats), .stat_handoffs(stat_handoffs),
`endif
        .IRB_CEN(IRB_CEN), .IRB_WEN(IRB_WEN), .IRB_A(IRB_A), .IRB_D(IRB_D), .IRB_Q(IRB_Q)
    );

    // SRAM environment: registered read port, write on active-low enables.
    logic [7:0] sram [64];
    logic [7:0] sram_q = 8'h00;
    assign IRB_Q = sram_q;
    always @(posedge clk) begin
        if (!IRB_CEN) begin
            if (!IRB_WEN) sram[IRB_A] <= IRB_D;
            else          sram_q      <= sram[IRB_A];
        end
    end

    typedef struct packed {
        logic       rw;
        logic [5:0] addr;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t q0[$], q1[$];
    bit    en[2];

    // Reference model: owner -1 = nobody, else master index.
    int         mown, mptr, mcnt, mho;
    int         mst[2];
    bit         mrv[2];
    logic [7:0] mrd[2];
    logic [7:0] mmem[64];

    int          n_chk = 0, n_fail = 0;
    logic [35:0] obs, expv;
    logic        og0, og1, ov0, ov1, ocen, owen;
    logic [7:0]  od0, od1;
    logic [35:0] exp_rst;

    function automatic logic [35:0] pins();
        return {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, IRB_CEN, IRB_WEN, IRB_A, IRB_D};
    endfunction

    task automatic model_clear();
        mown = -1; mptr = 0; mcnt = 0; mho = 0;
        for (int i = 0; i < 2; i++) begin
            mst[i] = 0; mrv[i] = 1'b0; mrd[i] = 8'h00;
        end
    endtask

    task automatic push(input int m, input logic rw, input logic [5:0] a, input logic [7:0] d, input logic l);
        beat_t b;
        b.rw = rw; b.addr = a; b.data = d; b.last = l;
        if (m == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        q0.delete(); q1.delete();
        en[0] = 1'b1; en[1] = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock: drive masters, capture pins and model expectation, advance model across the edge.
    task automatic step();
        logic       rq[2], rw[2], ls[2];
        logic [5:0] ad[2];
        logic [7:0] wd[2];
        bit         bt[2];
        beat_t      h;
        int         nown, nptr, ncnt, o, x, ca;
        bit         ea, eb, ec;
        bit         nrv[2];
        logic       ecen, ewen;
        logic [5:0] eadr;
        logic [7:0] edat;
        for (int i = 0; i < 2; i++) begin
            rq[i] = en[i] && ((i == 0) ? (q0.size() > 0) : (q1.size() > 0));
            bt[i] = rq[i] && (mown == i);
            if (bt[i]) begin
                h = (i == 0) ? q0[0] : q1[0];
                rw[i] = h.rw; ad[i] = h.addr; wd[i] = h.data; ls[i] = h.last;
            end else begin
                rw[i] = 1'($urandom_range(0, 1));
                ad[i] = 6'($urandom_range(0, 63));
                wd[i] = 8'($urandom_range(0, 255));
                ls[i] = 1'($urandom_range(0, 1));
            end
        end
        m0_req = rq[0]; m0_rw = rw[0]; m0_addr = ad[0]; m0_wdata = wd[0]; m0_last = ls[0];
        m1_req = rq[1]; m1_rw = rw[1]; m1_addr = ad[1]; m1_wdata = wd[1]; m1_last = ls[1];
        #1;
        og0 = m0_gnt; og1 = m1_gnt; ov0 = m0_rvalid; ov1 = m1_rvalid;
        od0 = m0_rdata; od1 = m1_rdata; ocen = IRB_CEN; owen = IRB_WEN;
        obs = pins();
        ecen = !(bt[0] || bt[1]);
        ewen = bt[0] ? rw[0] : (bt[1] ? rw[1] : 1'b1);
        eadr = bt[0] ? ad[0] : (bt[1] ? ad[1] : 6'h00);
        edat = bt[0] ? wd[0] : (bt[1] ? wd[1] : 8'h00);
        expv = {bt[0], bt[1], mrv[0], mrv[1], mrv[0] ? mrd[0] : 8'h00, mrv[1] ? mrd[1] : 8'h00,
                ecen, ewen, eadr, edat};
        if (mown < 0) begin
            ncnt = 0; nptr = mptr;
            if (rq[0] && rq[1]) nown = mptr;
            else if (rq[0])     nown = 0;
            else if (rq[1])     nown = 1;
            else                nown = -1;
        end else begin
            o = mown; x = 1 - o;
            ca = mcnt + (bt[o] ? 1 : 0);
            if (ca > MB) ca = MB;
            ea = bt[o] && ls[o];
            eb = !rq[o];
            ec = (ca >= MB) && rq[x];
            if (ea || eb || ec) begin
                nptr = x; nown = rq[x] ? x : -1; ncnt = 0;
                if (ec && !ea && !eb && mho < 255) mho++;
            end else begin
                nown = o; nptr = mptr; ncnt = ca;
            end
        end
        for (int i = 0; i < 2; i++) begin
            nrv[i] = bt[i] && rw[i];
            if (bt[i]) begin
                if (mst[i] < 65535) mst[i]++;
                if (rw[i]) mrd[i] = mmem[ad[i]];
                else       mmem[ad[i]] = wd[i];
            end
        end
        @(posedge clk);
        if (bt[0]) void'(q0.pop_front());
        if (bt[1]) void'(q1.pop_front());
        mown = nown; mptr = nptr; mcnt = ncnt;
        mrv[0] = nrv[0]; mrv[1] = nrv[1];
        @(negedge clk);
    endtask

    task automatic test_reset();
        m0_req = 1'b1; m1_req = 1'b1; m0_rw = 1'b0; m1_rw = 1'b1;
        m0_addr = 6'h2A; m1_addr = 6'h15; m0_wdata = 8'hC3; m1_wdata = 8'h3C;
        m0_last = 1'b0; m1_last = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_chk++;
            if (pins() !== exp_rst) begin
                n_fail++; $display("FAIL reset_hold cycle %0d: got %h expected %h", c, pins(), exp_rst);
            end
        end
`ifdef ARB_STAT_EN
        n_chk++;
        if ({stat0_beats, stat1_beats, stat_handoffs} !== 40'h0) begin
            n_fail++; $display("FAIL reset_stats: got %h expected 0", {stat0_beats, stat1_beats, stat_handoffs});
        end
`endif
        apply_reset();
        step();
        n_chk++;
        if (obs !== expv) begin n_fail++; $display("FAIL reset_idle: got %h expected %h", obs, expv); end
    endtask

    task automatic test_write_burst();
        int first = -1, ng = 0, nw = 0;
        for (int i = 0; i < 8; i++) push(0, 1'b0, 6'(i), 8'(8'h10 + i), i == 7);
        for (int c = 1; c <= 30 && q0.size() > 0; c++) begin
            step();
            n_chk++;
            if (obs !== expv) begin n_fail++; $display("FAIL wr_burst cycle %0d: got %h expected %h", c, obs, expv); end
            if (og0) begin ng++; if (first < 0) first = c; end
            if (!ocen && !owen) nw++;
        end
        n_chk++;
        if (first !== 2) begin n_fail++; $display("FAIL wr_first_gnt: got cycle %0d expected 2", first); end
        n_chk++;
        if (ng !== 8 || nw !== 8) begin n_fail++; $display("FAIL wr_beats: got gnt %0d wen %0d expected 8 8", ng, nw); end
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (sram[i] !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL wr_mem[%0d]: got %h expected %h", i, sram[i], 8'(8'h10 + i)); end
        end
        step();
        n_chk++;
        if (obs !== expv || ocen !== 1'b1) begin n_fail++; $display("FAIL wr_idle: got %h expected %h", obs, expv); end
    endtask

    task automatic test_tie();
        int c0 = -1, l0 = -1, f1 = -1, firstw = -1;
        apply_reset();
        for (int i = 0; i < 3; i++) push(0, 1'b0, 6'(20 + i), 8'(i), i == 2);
        for (int i = 0; i < 3; i++) push(1, 1'b0, 6'(30 + i), 8'(i + 8'h40), i == 2);
        for (int c = 0; c < 40 && (q0.size() > 0 || q1.size() > 0); c++) begin
            step();
            n_chk++;
            if (obs !== expv) begin n_fail++; $display("FAIL tie cycle %0d: got %h expected %h", c, obs, expv); end
            if ((og0 || og1) && firstw < 0) firstw = og0 ? 0 : 1;
            if (og0) begin l0 = c; if (c0 < 0) c0 = c; end
            if (og1 && f1 < 0) f1 = c;
        end
        n_chk++;
        if (firstw !== 0) begin n_fail++; $display("FAIL tie_first: got master %0d expected 0", firstw); end
        n_chk++;
        if (f1 !== l0 + 1 || l0 < 0) begin n_fail++; $display("FAIL tie_no_bubble: got m1 cycle %0d expected %0d", f1, l0 + 1); end
        push(0, 1'b0, 6'd40, 8'h55, 1'b1);
        push(1, 1'b0, 6'd41, 8'h66, 1'b1);
        step();
        step();
        n_chk++;
        if (obs !== expv || og0 !== 1'b1 || og1 !== 1'b0) begin
            n_fail++; $display("FAIL tie_ptr: got gnt %b%b expected 10", og0, og1);
        end
        for (int c = 0; c < 10 && (q0.size() > 0 || q1.size() > 0); c++) step();
    endtask

    task automatic test_read();
        bit prev = 1'b0;
        int hits = 0;
        sram[5] = 8'hA5; mmem[5] = 8'hA5;
        for (int i = 0; i < 3; i++) push(1, 1'b1, 6'd5, 8'h00, i == 2);
        for (int c = 0; c < 20; c++) begin
            step();
            n_chk++;
            if (obs !== expv) begin n_fail++; $display("FAIL rd cycle %0d: got %h expected %h", c, obs, expv); end
            if (prev) begin
                hits++;
                n_chk++;
                if (ov1 !== 1'b1 || od1 !== 8'hA5) begin n_fail++; $display("FAIL rd_data: got v=%b d=%h expected 1 a5", ov1, od1); end
            end
            n_chk++;
            if (ov0 !== 1'b0) begin n_fail++; $display("FAIL rd_m0_quiet: got rvalid %b expected 0", ov0); end
            prev = og1;
            if (q1.size() == 0 && !prev) break;
        end
        n_chk++;
        if (hits !== 3) begin n_fail++; $display("FAIL rd_count: got %0d expected 3", hits); end
    endtask

    task automatic test_max_burst();
        int seq[$];
        int runs[$];
        int fc = -1, lc = -1, ng = 0;
        apply_reset();
        for (int i = 0; i < 20; i++) push(0, 1'b0, 6'(i), 8'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 8; i++) push(1, 1'b1, 6'($urandom_range(0, 63)), 8'h00, 1'b0);
        for (int c = 0; c < 120 && (q0.size() > 0 || q1.size() > 0); c++) begin
            step();
            n_chk++;
            if (obs !== expv) begin n_fail++; $display("FAIL mb cycle %0d: got %h expected %h", c, obs, expv); end
            if (og0 || og1) begin
                seq.push_back(og0 ? 0 : 1);
                if (fc < 0) fc = c;
                lc = c;
            end
        end
        for (int i = 0; i < seq.size(); i++) begin
            if (i == 0 || seq[i] != seq[i-1]) runs.push_back(1);
            else runs[runs.size()-1]++;
        end
        n_chk++;
        if (runs.size() !== 3 || runs[0] !== 8 || runs[1] !== 8 || runs[2] !== 12) begin
            n_fail++; $display("FAIL mb_runs: got %0d runs first %0d expected 8/8/12", runs.size(), runs.size() > 0 ? runs[0] : -1);
        end
        n_chk++;
        if (lc - fc + 1 !== 28 || seq.size() !== 28) begin n_fail++; $display("FAIL mb_contiguous: got span %0d beats %0d expected 28", lc - fc + 1, seq.size()); end
`ifdef ARB_STAT_EN
        n_chk++;
        if (stat0_beats !== 16'd20 || stat1_beats !== 16'd8 || stat_handoffs !== 8'd2) begin
            n_fail++; $display("FAIL mb_stats: got %0d %0d %0d expected 20 8 2", stat0_beats, stat1_beats, stat_handoffs);
        end
`endif
        fc = -1; lc = -1;
        for (int i = 0; i < 20; i++) push(0, 1'b0, 6'(i + 32), 8'($urandom_range(0, 255)), 1'b0);
        for (int c = 0; c < 60 && q0.size() > 0; c++) begin
            step();
            n_chk++;
            if (obs !== expv) begin n_fail++; $display("FAIL mb_solo cycle %0d: got %h expected %h", c, obs, expv); end
            if (og0) begin ng++; if (fc < 0) fc = c; lc = c; end
        end
        n_chk++;
        if (ng !== 20 || lc - fc + 1 !== 20) begin n_fail++; $display("FAIL mb_solo_run: got %0d beats span %0d expected 20", ng, lc - fc + 1); end
    endtask

    task automatic test_reset_mid();
        int ng = 0;
        apply_reset();
        for (int i = 0; i < 10; i++) push(0, 1'b1, 6'($urandom_range(0, 63)), 8'h00, 1'b0);
        for (int c = 0; c < 20 && ng < 4; c++) begin
            step();
            n_chk++;
            if (obs !== expv) begin n_fail++; $display("FAIL mid cycle %0d: got %h expected %h", c, obs, expv); end
            if (og0) ng++;
        end
        #2;
        n_chk++;
        if (m0_gnt !== 1'b1 || m0_rvalid !== 1'b1 || IRB_CEN !== 1'b0) begin
            n_fail++; $display("FAIL mid_pre: got gnt %b rv %b cen %b expected 1 1 0", m0_gnt, m0_rvalid, IRB_CEN);
        end
        reset = 1'b0;
        #1;
        n_chk++;
        if (pins() !== exp_rst) begin n_fail++; $display("FAIL mid_async: got %h expected %h", pins(), exp_rst); end
        @(negedge clk);
        q0.delete(); q1.delete();
        model_clear();
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        push(0, 1'b0, 6'd50, 8'h77, 1'b1);
        push(1, 1'b0, 6'd51, 8'h88, 1'b1);
        step();
        step();
        n_chk++;
        if (obs !== expv || og0 !== 1'b1 || og1 !== 1'b0) begin
            n_fail++; $display("FAIL mid_after: got gnt %b%b expected 10", og0, og1);
        end
        for (int c = 0; c < 10 && (q0.size() > 0 || q1.size() > 0); c++) step();
    endtask

    task automatic test_random();
        int len;
        bit lastf;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (((m == 0) ? q0.size() : q1.size()) == 0 && $urandom_range(0, 3) == 0) begin
                    len = $urandom_range(1, 14);
                    lastf = 1'($urandom_range(0, 1));
                    for (int i = 0; i < len; i++)
                        push(m, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                             8'($urandom_range(0, 255)), lastf && (i == len - 1));
                end
                en[m] = ($urandom_range(0, 7) != 0);
            end
            step();
            n_chk++;
            if (obs !== expv) begin n_fail++; $display("FAIL rand cycle %0d: got %h expected %h", c, obs, expv); end
        end
        en[0] = 1'b1; en[1] = 1'b1;
        for (int c = 0; c < 200 && (q0.size() > 0 || q1.size() > 0); c++) begin
            step();
            n_chk++;
            if (obs !== expv) begin n_fail++; $display("FAIL rand_drain cycle %0d: got %h expected %h", c, obs, expv); end
        end
        n_chk++;
        if (q0.size() != 0 || q1.size() != 0) begin n_fail++; $display("FAIL rand_timeout: got %0d/%0d beats left expected 0", q0.size(), q1.size()); end
`ifdef ARB_STAT_EN
        n_chk++;
        if (stat0_beats !== 16'(mst[0]) || stat1_beats !== 16'(mst[1]) || stat_handoffs !== 8'(mho)) begin
            n_fail++; $display("FAIL rand_stats: got %0d %0d %0d expected %0d %0d %0d",
                               stat0_beats, stat1_beats, stat_handoffs, mst[0], mst[1], mho);
        end
`endif
    endtask

    initial begin
        exp_rst = {20'h0, 2'b11, 14'h0};
        for (int i = 0; i < 64; i++) begin
            sram[i] = 8'(i * 3);
            mmem[i] = 8'(i * 3);
        end
        en[0] = 1'b1; en[1] = 1'b1;
        model_clear();
        test_reset();
        test_write_burst();
        test_tie();
        test_read();
        test_max_burst();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
